// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite responder in front of a NUM_REGS x DATA_WIDTH register file.
// Latency: the last AW/W handshake at cycle N commits the write and raises BVALID at N+1.
//          An AR handshake at N raises RVALID at N+1.
// Backpressure: B and R beats are held with stable payload until BREADY/RREADY.
//               AWREADY/WREADY/ARREADY stay low while a response is outstanding.
//
// Ports
//   ACLK, ARESETN          clock (posedge) and synchronous active-low reset
//   S_AW*                  write address channel (AWADDR, AWVALID, AWREADY)
//   S_W*                   write data channel (WDATA, WSTRB, WVALID, WREADY)
//   S_B*                   write response channel (BRESP, BVALID, BREADY)
//   S_AR*                  read address channel (ARADDR, ARVALID, ARREADY)
//   S_R*                   read data channel (RDATA, RRESP, RVALID, RREADY)
//
// Address decode: idx = addr[ADDR_LSB +: clog2(NUM_REGS)+1].
// The low ADDR_LSB bits are ignored. An access is out of range, and answered with
// SLVERR, if any bit above the idx field is set or if idx >= NUM_REGS.

module axi4_lite_slave_regs #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  // write address
  input  logic [ADDR_WIDTH-1:0]   S_AWADDR,
  input  logic                    S_AWVALID,
  output logic                    S_AWREADY,
  // write data
  input  logic [DATA_WIDTH-1:0]   S_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S_WSTRB,
  input  logic                    S_WVALID,
  output logic                    S_WREADY,
  // write response
  output logic [1:0]              S_BRESP,
  output logic                    S_BVALID,
  input  logic                    S_BREADY,
  // read address
  input  logic [ADDR_WIDTH-1:0]   S_ARADDR,
  input  logic                    S_ARVALID,
  output logic                    S_ARREADY,
  // read data
  output logic [DATA_WIDTH-1:0]   S_RDATA,
  output logic [1:0]              S_RRESP,
  output logic                    S_RVALID,
  input  logic                    S_RREADY
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IW       = $clog2(NUM_REGS);
  localparam int IDX_W    = IW + 1;
  localparam logic [IDX_W-1:0] NREG = IDX_W'(NUM_REGS);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // ---------------------------------------------------------------------------
  // Address decode helpers
  // ---------------------------------------------------------------------------
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    logic [IDX_W-1:0]      idx;
    logic [ADDR_WIDTH-1:0] hi;
    idx = a[ADDR_LSB +: IDX_W];
    hi  = a >> (ADDR_LSB + IDX_W);
    return (hi == '0) && (idx < NREG);
  endfunction

  function automatic logic [IW-1:0] reg_sel(input logic [ADDR_WIDTH-1:0] a);
    return a[ADDR_LSB +: IW];
  endfunction

  // ---------------------------------------------------------------------------
  // Reset recovery: keeps every READY low for the cycle after a reset edge, so
  // all outputs read zero then even though the FSMs are already idle.
  // ---------------------------------------------------------------------------
  logic run_q;

  always_ff @(posedge ACLK) begin
    if (!ARESETN) run_q <= 1'b0;
    else          run_q <= 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  // ---------------------------------------------------------------------------
  // Write channel
  // ---------------------------------------------------------------------------
  typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_t;

  w_state_t              w_state_q, w_state_d;
  logic                  aw_held_q, w_held_q;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     wstrb_q;
  logic [1:0]            bresp_q;

  logic                  aw_hs, w_hs, aw_ok, w_ok, commit;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]     wr_strb;
  logic                  wr_in_range;
  logic [IW-1:0]         wr_sel;

  assign aw_hs = S_AWVALID && S_AWREADY;
  assign w_hs  = S_WVALID && S_WREADY;
  assign aw_ok = aw_held_q || aw_hs;
  assign w_ok  = w_held_q || w_hs;

  // The write commits on the edge that completes the pair, whether the second
  // half arrives live or both were captured earlier. Live channel values are
  // used for whichever half has not been captured yet.
  assign commit  = (w_state_q == W_IDLE) && aw_ok && w_ok;
  assign wr_addr = aw_held_q ? awaddr_q : S_AWADDR;
  assign wr_data = w_held_q ? wdata_q : S_WDATA;
  assign wr_strb = w_held_q ? wstrb_q : S_WSTRB;
  assign wr_in_range = in_range(wr_addr);
  assign wr_sel      = reg_sel(wr_addr);

  // State register
  always_ff @(posedge ACLK) begin
    if (!ARESETN) w_state_q <= W_IDLE;
    else          w_state_q <= w_state_d;
  end

  // Next-state logic
  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (commit)   w_state_d = W_RESP;
      W_RESP:  if (S_BREADY) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    S_AWREADY = run_q && (w_state_q == W_IDLE) && !aw_held_q;
    S_WREADY  = run_q && (w_state_q == W_IDLE) && !w_held_q;
    S_BVALID  = (w_state_q == W_RESP);
    S_BRESP   = (w_state_q == W_RESP) ? bresp_q : RESP_OKAY;
  end

  // Capture of a half-transaction that arrives ahead of its partner. The held
  // flags clear on commit; READYs are masked by the state in W_RESP anyway.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= RESP_OKAY;
    end else if (commit) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      bresp_q   <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
    end else begin
      if (aw_hs) begin
        aw_held_q <= 1'b1;
        awaddr_q  <= S_AWADDR;
      end
      if (w_hs) begin
        w_held_q <= 1'b1;
        wdata_q  <= S_WDATA;
        wstrb_q  <= S_WSTRB;
      end
    end
  end

  // Byte-enabled register update
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (commit && wr_in_range) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wr_strb[b]) regs_q[wr_sel][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read channel
  // ---------------------------------------------------------------------------
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

  r_state_t              r_state_q, r_state_d;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;
  logic                  ar_hs, rd_in_range;
  logic [IW-1:0]         rd_sel;

  assign ar_hs       = S_ARVALID && S_ARREADY;
  assign rd_in_range = in_range(S_ARADDR);
  assign rd_sel      = reg_sel(S_ARADDR);

  // State register
  always_ff @(posedge ACLK) begin
    if (!ARESETN) r_state_q <= R_IDLE;
    else          r_state_q <= r_state_d;
  end

  // Next-state logic
  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (ar_hs)    r_state_d = R_DATA;
      R_DATA:  if (S_RREADY) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    S_ARREADY = run_q && (r_state_q == R_IDLE);
    S_RVALID  = (r_state_q == R_DATA);
    S_RDATA   = (r_state_q == R_DATA) ? rdata_q : '0;
    S_RRESP   = (r_state_q == R_DATA) ? rresp_q : RESP_OKAY;
  end

  // Read data is sampled from the register file on the AR handshake edge, so
  // a write committing on that same edge is not yet visible (old value).
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else if (ar_hs) begin
      rdata_q <= rd_in_range ? regs_q[rd_sel] : '0;
      rresp_q <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
    end
  end

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Self-checking bench for axi4_lite_slave_regs (default parameters).
// A plain array models the register file; expected responses are derived from
// byte-address arithmetic (in range iff addr/4 < 16) and byte-wise WSTRB merges.

module tb_axi4_lite_slave_regs;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic [31:0] S_AWADDR = '0;
  logic        S_AWVALID = 1'b0;
  logic        S_AWREADY;
  logic [31:0] S_WDATA = '0;
  logic [3:0]  S_WSTRB = '0;
  logic        S_WVALID = 1'b0;
  logic        S_WREADY;
  logic [1:0]  S_BRESP;
  logic        S_BVALID;
  logic        S_BREADY = 1'b0;
  logic [31:0] S_ARADDR = '0;
  logic        S_ARVALID = 1'b0;
  logic        S_ARREADY;
  logic [31:0] S_RDATA;
  logic [1:0]  S_RRESP;
  logic        S_RVALID;
  logic        S_RREADY = 1'b0;

  axi4_lite_slave_regs #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AWADDR(S_AWADDR), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
    .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
    .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
    .S_ARADDR(S_ARADDR), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;
  logic [31:0] mdl [16];

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit mdl_in(input logic [31:0] a);
    return (a / 4) < 16;
  endfunction

  function automatic logic [31:0] mdl_rd(input logic [31:0] a);
    logic [3:0] i;
    i = a[5:2];
    return mdl_in(a) ? mdl[i] : 32'h0;
  endfunction

  function automatic logic [1:0] mdl_resp(input logic [31:0] a);
    return mdl_in(a) ? 2'b00 : 2'b10;
  endfunction

  task automatic mdl_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [3:0] i;
    i = a[5:2];
    if (mdl_in(a))
      for (int b = 0; b < 4; b++)
        if (s[b]) mdl[i][8*b +: 8] = d[8*b +: 8];
  endtask

  // ---------------- bus tasks ----------------
  // AW and W are offered aw_dly/w_dly cycles after start. b_dly < 0 leaves
  // the B beat pending on return.
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int b_dly);
    bit aw_done = 0;
    bit w_done = 0;
    int cyc = 0;
    logic [1:0] er;
    er = mdl_resp(a);
    while (!(aw_done && w_done)) begin
      @(negedge ACLK);
      if (cyc > 50) begin
        S_AWVALID = 1'b0;
        S_WVALID = 1'b0;
        chk1("wr_handshake_timeout", 1'b1, 1'b0);
        return;
      end
      chk1("awready_idle", S_AWREADY, !aw_done);
      chk1("wready_idle", S_WREADY, !w_done);
      S_AWVALID = !aw_done && (cyc >= aw_dly);
      S_AWADDR  = S_AWVALID ? a : $urandom;
      S_WVALID  = !w_done && (cyc >= w_dly);
      S_WDATA   = S_WVALID ? d : $urandom;
      S_WSTRB   = s;
      if (S_AWVALID && S_AWREADY) aw_done = 1;
      if (S_WVALID && S_WREADY) w_done = 1;
      cyc++;
    end
    @(negedge ACLK);
    S_AWVALID = 1'b0;
    S_WVALID  = 1'b0;
    chk1("bvalid_latency", S_BVALID, 1'b1);
    mdl_wr(a, d, s);
    if (b_dly < 0) return;
    for (int i = 0; i < b_dly; i++) begin
      chk1("bvalid_hold", S_BVALID, 1'b1);
      chkv("bresp_hold", 32'(S_BRESP), 32'(er));
      chk1("awready_resp", S_AWREADY, 1'b0);
      chk1("wready_resp", S_WREADY, 1'b0);
      @(negedge ACLK);
    end
    chkv("bresp", 32'(S_BRESP), 32'(er));
    S_BREADY = 1'b1;
    @(negedge ACLK);
    S_BREADY = 1'b0;
    chk1("bvalid_clear", S_BVALID, 1'b0);
    chkv("bresp_clear", 32'(S_BRESP), 32'h0);
  endtask

  task automatic axi_read(input logic [31:0] a, input int r_dly);
    logic [31:0] ed;
    logic [1:0] er;
    bit done = 0;
    int cyc = 0;
    ed = mdl_rd(a);
    er = mdl_resp(a);
    while (!done) begin
      @(negedge ACLK);
      if (cyc > 50) begin
        S_ARVALID = 1'b0;
        chk1("rd_handshake_timeout", 1'b1, 1'b0);
        return;
      end
      S_ARVALID = 1'b1;
      S_ARADDR  = a;
      done = S_ARREADY;
      cyc++;
    end
    @(negedge ACLK);
    S_ARVALID = 1'b0;
    chk1("rvalid_latency", S_RVALID, 1'b1);
    for (int i = 0; i < r_dly; i++) begin
      chkv("rdata_hold", S_RDATA, ed);
      chkv("rresp_hold", 32'(S_RRESP), 32'(er));
      chk1("arready_data", S_ARREADY, 1'b0);
      @(negedge ACLK);
    end
    chkv("rdata", S_RDATA, ed);
    chkv("rresp", 32'(S_RRESP), 32'(er));
    S_RREADY = 1'b1;
    @(negedge ACLK);
    S_RREADY = 1'b0;
    chk1("rvalid_clear", S_RVALID, 1'b0);
    chkv("rdata_clear", S_RDATA, 32'h0);
  endtask

  task automatic outputs_zero();
    chk1("rst_awready", S_AWREADY, 1'b0);
    chk1("rst_wready", S_WREADY, 1'b0);
    chk1("rst_arready", S_ARREADY, 1'b0);
    chk1("rst_bvalid", S_BVALID, 1'b0);
    chk1("rst_rvalid", S_RVALID, 1'b0);
    chkv("rst_bresp", 32'(S_BRESP), 32'h0);
    chkv("rst_rresp", 32'(S_RRESP), 32'h0);
    chkv("rst_rdata", S_RDATA, 32'h0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d, old_v;
    for (int i = 0; i < 16; i++) mdl[i] = 32'h0;

    // reset
    ARESETN = 1'b0;
    repeat (3) @(negedge ACLK);
    outputs_zero();
    ARESETN = 1'b1;
    repeat (2) @(negedge ACLK);

    // full-word write and read back
    axi_write(32'h04, 32'hA5A5_A5A5, 4'hF, 0, 0, 0);
    axi_read(32'h04, 0);

    // partial-strobe merge
    axi_write(32'h08, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
    axi_write(32'h08, 32'h1234_5678, 4'b0101, 0, 0, 0);
    chkv("strobe_model", mdl_rd(32'h08), 32'hFF34_FF78);
    axi_read(32'h08, 0);

    // W ahead of AW by 3 cycles, then AW ahead of W
    axi_write(32'h10, 32'hCAFE_0001, 4'hF, 3, 0, 0);
    axi_write(32'h14, 32'hCAFE_0002, 4'hF, 0, 2, 0);
    axi_read(32'h10, 0);
    axi_read(32'h14, 0);

    // out of range: idx >= 16, and a high address bit set
    axi_write(32'h40, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
    axi_read(32'h40, 0);
    axi_write(32'h8000_0004, 32'hDEAD_BEEF, 4'hF, 1, 1, 1);
    axi_read(32'h8000_0004, 1);
    axi_read(32'h04, 0);

    // backpressure for 5 cycles
    axi_write(32'h18, 32'h0BAD_F00D, 4'hF, 0, 0, 5);
    axi_read(32'h18, 5);

    // same-register read/write ordering on reg 3
    axi_write(32'h0C, 32'h1111_1111, 4'hF, 0, 0, 0);
    old_v = mdl_rd(32'h0C);
    @(negedge ACLK);
    S_AWVALID = 1'b1; S_AWADDR = 32'h0C;
    @(negedge ACLK);
    S_AWVALID = 1'b0;
    chk1("aw_held_ready", S_AWREADY, 1'b0);
    S_WVALID = 1'b1; S_WDATA = 32'h2222_2222; S_WSTRB = 4'hF;
    S_ARVALID = 1'b1; S_ARADDR = 32'h0C;
    @(negedge ACLK);
    S_WVALID = 1'b0; S_ARVALID = 1'b0;
    chk1("same_edge_bvalid", S_BVALID, 1'b1);
    chk1("same_edge_rvalid", S_RVALID, 1'b1);
    chkv("same_edge_old", S_RDATA, old_v);
    mdl_wr(32'h0C, 32'h2222_2222, 4'hF);
    S_BREADY = 1'b1; S_RREADY = 1'b1;
    @(negedge ACLK);
    S_BREADY = 1'b0; S_RREADY = 1'b0;
    chk1("same_edge_bclr", S_BVALID, 1'b0);
    chk1("same_edge_rclr", S_RVALID, 1'b0);

    @(negedge ACLK);
    S_AWVALID = 1'b1; S_AWADDR = 32'h0C;
    @(negedge ACLK);
    S_AWVALID = 1'b0;
    S_WVALID = 1'b1; S_WDATA = 32'h3333_3333; S_WSTRB = 4'hF;
    @(negedge ACLK);
    S_WVALID = 1'b0;
    chk1("next_edge_bvalid", S_BVALID, 1'b1);
    mdl_wr(32'h0C, 32'h3333_3333, 4'hF);
    S_ARVALID = 1'b1; S_ARADDR = 32'h0C;
    chk1("next_edge_arready", S_ARREADY, 1'b1);
    S_BREADY = 1'b1;
    @(negedge ACLK);
    S_ARVALID = 1'b0; S_BREADY = 1'b0;
    chk1("next_edge_rvalid", S_RVALID, 1'b1);
    chkv("next_edge_new", S_RDATA, mdl_rd(32'h0C));
    S_RREADY = 1'b1;
    @(negedge ACLK);
    S_RREADY = 1'b0;

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) == 0) a = $urandom;
      else                           a = $urandom_range(0, 79);
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        axi_write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3));
      end else begin
        axi_read(a, $urandom_range(0, 3));
      end
    end

    // reset while BVALID is pending
    axi_write(32'h1C, 32'h7777_7777, 4'hF, 0, 0, -1);
    chk1("pre_reset_bvalid", S_BVALID, 1'b1);
    ARESETN = 1'b0;
    @(negedge ACLK);
    outputs_zero();
    ARESETN = 1'b1;
    for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
    @(negedge ACLK);
    for (int i = 0; i < 16; i++) axi_read(32'(i * 4), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
